// File: rtl/ac_motor_deadtime_gen_if.sv
// Gate-control bus between switch control and the dead-time generator.
// The master drives the command side; the generator (slave) returns gates and status.
interface ac_motor_deadtime_gen_if #(
    parameter int CHANNELS = 3,
    parameter int DELAY_W  = 11,
    parameter int MIN_ON_W = 8
);
    logic                enable;
    logic [DELAY_W-1:0]  delay;
    logic [MIN_ON_W-1:0] min_on;
    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] s_high;
    logic [CHANNELS-1:0] s_low;
    logic [CHANNELS-1:0] busy;
    logic                shoot_fault;

    modport master (
        output enable, delay, min_on, s,
        input  s_high, s_low, busy, shoot_fault
    );

    modport slave (
        input  enable, delay, min_on, s,
        output s_high, s_low, busy, shoot_fault
    );
endinterface

// File: rtl/ac_motor_deadtime_gen.sv
// Multi-leg break-before-make gate generator with programmable dead time.
// Optional minimum on-time hold is enabled by defining AC_MOTOR_DEADTIME_MIN_ON_EN.
module ac_motor_deadtime_lane #(
    parameter int DELAY_W  = 11,
    parameter int MIN_ON_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [DELAY_W-1:0]  delay,
    input  logic [MIN_ON_W-1:0] min_on,
    input  logic                s,
    output logic                s_high,
    output logic                s_low,
    output logic                busy
);
    typedef enum logic [1:0] {ST_OFF, ST_DEAD, ST_HIGH, ST_LOW} state_e;

    state_e             state_q, state_d;
    logic               tgt_q, tgt_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic               s_high_q, s_high_d;
    logic               s_low_q, s_low_d;
    logic               busy_q, busy_d;
    logic [DELAY_W-1:0] dly_eff;
    logic               hold;

`ifdef AC_MOTOR_DEADTIME_MIN_ON_EN
    logic [MIN_ON_W-1:0] mon_q, mon_d;
`else
    logic unused_min_on;
    assign unused_min_on = ^min_on;
`endif

    // A zero delay still guarantees one all-off cycle.
    assign dly_eff = (delay == '0) ? DELAY_W'(1) : delay;

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        hold    = 1'b0;
`ifdef AC_MOTOR_DEADTIME_MIN_ON_EN
        mon_d   = mon_q;
        hold    = (mon_q != '0);
`endif
        case (state_q)
            ST_OFF: begin
                state_d = ST_DEAD;
                tgt_d   = s;
                cnt_d   = dly_eff;
            end
            ST_DEAD: begin
                // A command glitch restarts the full gap toward the new target.
                if (s != tgt_q) begin
                    tgt_d = s;
                    cnt_d = dly_eff;
                end else if (cnt_q <= DELAY_W'(1)) begin
                    state_d = tgt_q ? ST_HIGH : ST_LOW;
                    cnt_d   = '0;
`ifdef AC_MOTOR_DEADTIME_MIN_ON_EN
                    mon_d   = min_on;
`endif
                end else begin
                    cnt_d = cnt_q - DELAY_W'(1);
                end
            end
            default: begin
                if (hold) begin
`ifdef AC_MOTOR_DEADTIME_MIN_ON_EN
                    mon_d = mon_q - MIN_ON_W'(1);
`endif
                end else if (s != (state_q == ST_HIGH)) begin
                    state_d = ST_DEAD;
                    tgt_d   = s;
                    cnt_d   = dly_eff;
                end
            end
        endcase

        if (!enable) begin
            state_d = ST_OFF;
            cnt_d   = '0;
`ifdef AC_MOTOR_DEADTIME_MIN_ON_EN
            mon_d   = '0;
`endif
        end

        s_high_d = (state_d == ST_HIGH);
        s_low_d  = (state_d == ST_LOW);
        busy_d   = (state_d == ST_OFF) || (state_d == ST_DEAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_OFF;
            tgt_q    <= 1'b0;
            cnt_q    <= '0;
            s_high_q <= 1'b0;
            s_low_q  <= 1'b0;
            busy_q   <= 1'b1;
`ifdef AC_MOTOR_DEADTIME_MIN_ON_EN
            mon_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
            s_high_q <= s_high_d;
            s_low_q  <= s_low_d;
            busy_q   <= busy_d;
`ifdef AC_MOTOR_DEADTIME_MIN_ON_EN
            mon_q    <= mon_d;
`endif
        end
    end

    assign s_high = s_high_q;
    assign s_low  = s_low_q;
    assign busy   = busy_q;
endmodule

module ac_motor_deadtime_gen #(
    parameter int CHANNELS = 3,
    parameter int DELAY_W  = 11,
    parameter int MIN_ON_W = 8
) (
    input logic                    clk,
    input logic                    rst,
    ac_motor_deadtime_gen_if.slave bus
);
    logic [CHANNELS-1:0] s_high_w, s_low_w, busy_w;
    logic                shoot_fault_q, shoot_fault_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        ac_motor_deadtime_lane #(
            .DELAY_W  (DELAY_W),
            .MIN_ON_W (MIN_ON_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .enable (bus.enable),
            .delay  (bus.delay),
            .min_on (bus.min_on),
            .s      (bus.s[i]),
            .s_high (s_high_w[i]),
            .s_low  (s_low_w[i]),
            .busy   (busy_w[i])
        );
    end

    // Sticky overlap monitor on the registered gates.
    always_comb begin
        shoot_fault_d = shoot_fault_q | (|(s_high_w & s_low_w));
    end

    always_ff @(posedge clk) begin
        if (rst) shoot_fault_q <= 1'b0;
        else     shoot_fault_q <= shoot_fault_d;
    end

    assign bus.s_high      = s_high_w;
    assign bus.s_low       = s_low_w;
    assign bus.busy        = busy_w;
    assign bus.shoot_fault = shoot_fault_q;
endmodule

// File: tb/tb_ac_motor_deadtime_gen.sv
// Directed and randomized bench for ac_motor_deadtime_gen against a time-based leg model.
module tb_ac_motor_deadtime_gen;
    localparam int CH = 3;
    localparam int DW = 11;
    localparam int MW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ac_motor_deadtime_gen_if #(.CHANNELS(CH), .DELAY_W(DW), .MIN_ON_W(MW)) bus ();

    ac_motor_deadtime_gen #(.CHANNELS(CH), .DELAY_W(DW), .MIN_ON_W(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int n = 0;
    // Model per leg: side -1 = gates off, else the gate (0 low / 1 high) that is on.
    int m_side [CH];
    int m_tgt  [CH];
    int m_rise [CH];
    bit m_dis  [CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, n);
        end
    endtask

    task automatic model_edge();
        int d;
        int sv;
        d = (int'(bus.delay) == 0) ? 1 : int'(bus.delay);
        for (int c = 0; c < CH; c++) begin
            sv = int'(bus.s[c]);
            if (rst) begin
                m_side[c] = -1; m_dis[c] = 1'b1; m_tgt[c] = 0; m_rise[c] = 0;
            end else if (!bus.enable) begin
                m_side[c] = -1; m_dis[c] = 1'b1;
            end else if (m_dis[c]) begin
                m_dis[c] = 1'b0; m_tgt[c] = sv; m_rise[c] = n + d;
            end else if (m_side[c] < 0) begin
                if (sv != m_tgt[c]) begin
                    m_tgt[c] = sv; m_rise[c] = n + d;
                end else if (n == m_rise[c]) begin
                    m_side[c] = m_tgt[c];
                end
            end else if (sv != m_side[c]) begin
                m_side[c] = -1; m_tgt[c] = sv; m_rise[c] = n + d;
            end
        end
    endtask

    task automatic step();
        logic [CH-1:0] eh, el, eb;
        @(posedge clk);
        n++;
        model_edge();
        #1;
        for (int c = 0; c < CH; c++) begin
            eh[c] = (m_side[c] == 1);
            el[c] = (m_side[c] == 0);
            eb[c] = (m_side[c] < 0);
        end
        chk("model_high", 32'(bus.s_high), 32'(eh));
        chk("model_low", 32'(bus.s_low), 32'(el));
        chk("model_busy", 32'(bus.busy), 32'(eb));
        chk("shoot_fault", 32'(bus.shoot_fault), 32'd0);
    endtask

    initial begin
        bit saw_high2;
        rst = 1'b1; bus.enable = 1'b0; bus.delay = '0; bus.min_on = '0; bus.s = '0;
        for (int c = 0; c < CH; c++) begin
            m_side[c] = -1; m_dis[c] = 1'b1; m_tgt[c] = 0; m_rise[c] = 0;
        end
        step(); step();
        chk("rst_high", 32'(bus.s_high), 32'd0);
        chk("rst_low", 32'(bus.s_low), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'b111);

        // Basic gap, delay 4
        rst = 1'b0; bus.enable = 1'b1; bus.delay = 11'd4; bus.s = 3'b000;
        step();
        repeat (3) step();
        chk("basic_low_off", 32'(bus.s_low), 32'd0);
        step();
        chk("basic_low_on", 32'(bus.s_low), 32'b111);
        bus.s = 3'b001;
        step();
        chk("basic_drop", 32'({bus.s_high[0], bus.s_low[0]}), 32'd0);
        repeat (3) step();
        chk("basic_gap_hold", 32'(bus.s_high), 32'd0);
        step();
        chk("basic_high_on", 32'(bus.s_high), 32'b001);

        // delay 0 acts as a single off cycle
        bus.delay = '0; bus.s = 3'b011;
        step();
        chk("d0_gap", 32'(bus.s_high), 32'b001);
        step();
        chk("d0_high", 32'(bus.s_high), 32'b011);

        // Glitch during dead time restarts the gap
        bus.delay = 11'd10; bus.s = 3'b111;
        saw_high2 = 1'b0;
        step(); saw_high2 |= bus.s_high[2];
        step(); saw_high2 |= bus.s_high[2];
        step(); saw_high2 |= bus.s_high[2];
        bus.s = 3'b011;
        step(); saw_high2 |= bus.s_high[2];
        repeat (9) begin
            step(); saw_high2 |= bus.s_high[2];
        end
        chk("glitch_gap", 32'(bus.s_low[2]), 32'd0);
        step(); saw_high2 |= bus.s_high[2];
        chk("glitch_low_on", 32'(bus.s_low[2]), 32'd1);
        chk("glitch_no_high", 32'(saw_high2), 32'd0);

        // Disable forces off immediately; re-enable waits a full gap
        bus.enable = 1'b0;
        step();
        chk("dis_high", 32'(bus.s_high), 32'd0);
        chk("dis_low", 32'(bus.s_low), 32'd0);
        chk("dis_busy", 32'(bus.busy), 32'b111);
        bus.enable = 1'b1; bus.delay = 11'd5;
        step();
        repeat (4) step();
        chk("reen_gap", 32'(bus.s_high), 32'd0);
        step();
        chk("reen_high", 32'(bus.s_high), 32'b011);
        chk("reen_low", 32'(bus.s_low), 32'b100);

        // Randomized stress against the model
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(7, 0) == 0) bus.s[c] = ~bus.s[c];
            if ($urandom_range(63, 0) == 0)
                bus.delay = ($urandom_range(15, 0) == 0) ? DW'($urandom_range(2047, 0))
                                                        : DW'($urandom_range(12, 0));
            bus.enable = ($urandom_range(299, 0) != 0);
            bus.min_on = MW'($urandom_range(255, 0));
            rst = (cyc == 2000 || cyc == 2001);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
